multiplier14: RTL and testbench
===============================

// Module: multiplier14
// PURPOSE
//  Pipelined shift-and-add multiply-accumulate: product_out = multiplicand_in * multiplier_in + addend_in.
//  It is the inverse partner of divider14 in the AR projection datapath. It rebuilds
//  dividend = quotient*divisor + remainder and scales homography terms back to pixel space.
//  Throughput is one operation per cycle, with the same pause/stall semantics as divider14.
// PARAMETERS
//  WIDTH  14  operand/result width in bits; must be even (pipeline is registered every 2nd bit-stage)
// PORTS
//  clk_in           input   1      system clock
//  rst_in           input   1      asynchronous, active-high reset
//  multiplicand_in  input   WIDTH  unsigned operand A
//  multiplier_in    input   WIDTH  unsigned operand B (consumed MSB-first, one bit per stage)
//  addend_in        input   WIDTH  unsigned term added at the final stage
//  data_valid_in    input   1      operands valid this cycle
//  pause            input   1      1 = freeze every pipeline register (inputs ignored)
//  product_out      output  WIDTH  result (see CONFIGURATION for overflow handling)
//  data_valid_out   output  1      product_out valid this cycle
//  overflow_out     output  1      full result exceeded 2^WIDTH-1 (qualified by data_valid_out)
// BEHAVIOUR
//  - One clock domain: clk_in. rst_in is asynchronous and active-high.
//  - Reset clears all stage registers. Reset values: product_out=0, data_valid_out=0, overflow_out=0.
//  - Bit-stage i (i=0..WIDTH-1) computes acc_i = (acc_{i-1}<<1) + (B[WIDTH-1-i] ? A : 0), with acc_{-1}=0.
//    The accumulator is 2*WIDTH+1 bits, so it never wraps internally.
//  - Even-numbered stages are combinational and odd-numbered stages are registered.
//    The final add of addend_in (carried down the pipe) happens in the last registered stage.
//  - Latency: WIDTH/2 cycles (7 for WIDTH=14) from data_valid_in to data_valid_out.
//    There are no bubbles, and back-to-back inputs give back-to-back outputs.
//  - A, B, addend and valid travel alongside the accumulator, one copy per registered stage.
//  - pause=1: every register holds its value. Outputs stay stable for the whole pause.
//    The input presented during a pause cycle is dropped, the same as in divider14.
//  - If rst_in and pause are both asserted, reset wins.
//  - rst_in mid-operation: all in-flight results are discarded, and data_valid_out is 0 on the next edge.
//  - There is no handshake back-pressure. The upstream block must honour pause itself.
//  - B=0 or A=0: result = addend. A=B=2^WIDTH-1 with addend=2^WIDTH-1: full result fits in 2*WIDTH+1 bits.
// CONFIGURATION
//  - Macro MULT14_SATURATE_EN.
//  - Defined: full = A*B+addend. If full > 2^WIDTH-1, product_out = all-ones and overflow_out=1.
//    Otherwise product_out = full and overflow_out=0.
//  - Undefined: product_out = full[WIDTH-1:0] (wraps), and overflow_out still flags full > 2^WIDTH-1.
//    The overflow compare logic is always present; only the output mux is compiled in or out.
// STRUCTURE
//  - Package mult_pkg: localparam ACC_W = 2*WIDTH+1.
//  - mult_pkg: typedef struct stage_t {acc, a, b, addend, valid}.
//  - mult_pkg: function shift_add(stage_t, bit_idx) returning the next stage_t.
//  - Sub-module mult_pair_stage: one combinational stage followed by one registered stage, with pause/reset.
//    The top level instantiates it WIDTH/2 times and handles the final addend add and the saturate/wrap mux.
// TESTING
//  - Basic: A=100, B=50, addend=7 -> after 7 cycles product_out=5007, overflow_out=0, data_valid_out=1.
//  - Round trip with divider14: A=324 (12000/37), B=37, addend=12 -> product_out=12000.
//  - Overflow: A=200, B=100, addend=0.
//    SATURATE_EN defined -> product_out=16383, overflow_out=1.
//    SATURATE_EN undefined -> product_out=20000 mod 16384 = 3616, overflow_out=1.
//  - Streaming: 20 consecutive valid inputs (A=i, B=i+1, addend=i) -> 20 consecutive outputs i*(i+1)+i, in order.
//  - Pause: assert pause for 3 cycles while 3 ops are in flight.
//    Outputs stay frozen during the pause, and all 3 results emerge after resume, delayed by exactly 3 cycles.
//  - Async reset: pulse rst_in between clock edges with 5 ops in flight.
//    data_valid_out=0 and product_out=0 immediately. A new op issued after release has latency 7.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and the bit-stage step for the multiplier14 shift-and-add pipeline.
package mult_pkg;

  localparam int unsigned WIDTH = 14;
  localparam int unsigned ACC_W = 2 * WIDTH + 1;
  localparam int unsigned PAIRS = WIDTH / 2;
  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [ACC_W-1:0] acc_t;

  // Payload carried from one registered stage to the next
  typedef struct packed {
    acc_t  acc;
    word_t a;
    word_t b;
    word_t addend;
    logic  valid;
  } stage_t;

  // One bit-stage: shift the accumulator and add A when B's bit (MSB-first) is set
  function automatic stage_t shift_add(stage_t s, int unsigned bit_idx);
    stage_t n;
    n = s;
    n.acc = (s.acc << 1) + (s.b[IDX_W'(WIDTH - 1 - bit_idx)] ? ACC_W'(s.a) : '0);
    return n;
  endfunction

endpackage

// File: rtl/mult_pair_stage.sv
// Two bit-stages of the multiplier: an even (combinational) stage feeding an
// odd (registered) stage. The last pair also folds in the addend.
module mult_pair_stage
  import mult_pkg::*;
#(
  parameter int unsigned IDX  = 0,
  parameter bit          LAST = 1'b0
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   pause,
  input  stage_t d,
  output stage_t q
);

  stage_t nxt_c;

  // Even stage then odd stage; the final pair adds the carried addend
  always_comb begin
    nxt_c = shift_add(shift_add(d, 2 * IDX), 2 * IDX + 1);
    if (LAST) begin
      nxt_c.acc = nxt_c.acc + ACC_W'(nxt_c.addend);
    end
  end

  // Stage register: cleared by reset, frozen while paused
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      q <= '0;
    end else if (!pause) begin
      q <= nxt_c;
    end
  end

endmodule

// File: rtl/multiplier14.sv
// Pipelined multiply-accumulate: product = A*B + addend, latency WIDTH/2 cycles.
// Build option MULT14_SATURATE_EN: clamp to all-ones on overflow instead of wrapping.
module multiplier14
  import mult_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] multiplicand_in,
  input  logic [WIDTH-1:0] multiplier_in,
  input  logic [WIDTH-1:0] addend_in,
  input  logic             data_valid_in,
  input  logic             pause,
  output logic [WIDTH-1:0] product_out,
  output logic             data_valid_out,
  output logic             overflow_out
);

  stage_t pipe [PAIRS+1];

  assign pipe[0] = '{acc: '0, a: multiplicand_in, b: multiplier_in,
                     addend: addend_in, valid: data_valid_in};

  genvar k;
  generate
    for (k = 0; k < PAIRS; k++) begin : g_pair
      mult_pair_stage #(
        .IDX (k),
        .LAST(k == PAIRS - 1)
      ) u_pair (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .pause (pause),
        .d     (pipe[k]),
        .q     (pipe[k+1])
      );
    end
  endgenerate

  // Result decode from the final stage: overflow flag always, then saturate or wrap
  always_comb begin
    overflow_out   = |pipe[PAIRS].acc[ACC_W-1:WIDTH];
    data_valid_out = pipe[PAIRS].valid;
`ifdef MULT14_SATURATE_EN
    product_out    = overflow_out ? '1 : pipe[PAIRS].acc[WIDTH-1:0];
`else
    product_out    = pipe[PAIRS].acc[WIDTH-1:0];
`endif
  end

endmodule

// File: tb/tb_multiplier14.sv
// Self-checking bench for multiplier14 against an arithmetic reference model.
module tb_multiplier14;
  import mult_pkg::*;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic [WIDTH-1:0]  multiplicand_in = '0;
  logic [WIDTH-1:0]  multiplier_in = '0;
  logic [WIDTH-1:0]  addend_in = '0;
  logic              data_valid_in = 1'b0;
  logic              pause = 1'b0;
  logic [WIDTH-1:0]  product_out;
  logic              data_valid_out;
  logic              overflow_out;

  int checks = 0;
  int failures = 0;
  int tick = 0;
  int unsigned exp_prod [int];
  bit          exp_ovf  [int];

  always #5 clk_in = ~clk_in;

  multiplier14 dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .multiplicand_in(multiplicand_in),
    .multiplier_in  (multiplier_in),
    .addend_in      (addend_in),
    .data_valid_in  (data_valid_in),
    .pause          (pause),
    .product_out    (product_out),
    .data_valid_out (data_valid_out),
    .overflow_out   (overflow_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: full-precision A*B+addend, then saturate or wrap
  function automatic void model(input int a, input int b, input int ad,
                                output int unsigned p, output bit o);
    longint full;
    full = longint'(a) * longint'(b) + longint'(ad);
    o = full > 16383;
`ifdef MULT14_SATURATE_EN
    p = o ? 16383 : int'(full);
`else
    p = int'(full % 16384);
`endif
  endfunction

  // One clock: drive inputs, update the model at the edge, check outputs 1ns later
  task automatic step(input bit v, input int a, input int b, input int ad, input bit p);
    int unsigned ep;
    bit eo;
    data_valid_in   = v;
    multiplicand_in = WIDTH'(a);
    multiplier_in   = WIDTH'(b);
    addend_in       = WIDTH'(ad);
    pause           = p;
    @(posedge clk_in);
    if (!p) begin
      tick++;
      if (v) begin
        model(a, b, ad, ep, eo);
        exp_prod[tick] = ep;
        exp_ovf[tick]  = eo;
      end
    end
    #1;
    if (exp_prod.exists(tick - 6)) begin
      check("valid", 32'(data_valid_out), 1);
      check("product", 32'(product_out), exp_prod[tick - 6]);
      check("overflow", 32'(overflow_out), 32'(exp_ovf[tick - 6]));
    end else begin
      check("idle_valid", 32'(data_valid_out), 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0);
  endtask

  function automatic int pick_operand();
    int sel;
    sel = int'($urandom_range(0, 5));
    if (sel == 0) return 0;
    if (sel == 1) return 16383;
    return int'($urandom_range(0, 16383));
  endfunction

  initial begin
    #1 rst_in = 1'b1;
    #1;
    check("rst_valid", 32'(data_valid_out), 0);
    check("rst_product", 32'(product_out), 0);
    check("rst_overflow", 32'(overflow_out), 0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_in = 1'b0;

    // Basic case with a directly stated expectation on the 7th edge
    step(1'b1, 100, 50, 7, 1'b0);
    idle(6);
    check("basic_5007", 32'(product_out), 5007);

    // Rebuild a divider result: 324*37+12
    step(1'b1, 324, 37, 12, 1'b0);
    idle(6);
    check("roundtrip_12000", 32'(product_out), 12000);

    // Overflow, zero operands and the largest operands
    step(1'b1, 200, 100, 0, 1'b0);
    step(1'b1, 0, 12345, 77, 1'b0);
    step(1'b1, 9999, 0, 16383, 1'b0);
    step(1'b1, 16383, 16383, 16383, 1'b0);
    step(1'b1, 1, 16383, 0, 1'b0);
    idle(8);

    // Back-to-back streaming
    for (int i = 0; i < 20; i++) step(1'b1, i, i + 1, i, 1'b0);
    idle(8);

    // Pause with three ops in flight; inputs offered while paused are dropped
    step(1'b1, 11, 13, 1, 1'b0);
    step(1'b1, 123, 45, 6, 1'b0);
    step(1'b1, 4000, 5, 3, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0);
    step(1'b1, 7, 7, 7, 1'b1);
    step(1'b1, 8, 8, 8, 1'b1);
    step(1'b1, 9, 9, 9, 1'b1);
    idle(8);

    // Asynchronous reset between edges with five ops in flight
    for (int i = 0; i < 5; i++) step(1'b1, 300 + i, 20 + i, i, 1'b0);
    #3 rst_in = 1'b1;
    #1;
    check("async_rst_valid", 32'(data_valid_out), 0);
    check("async_rst_product", 32'(product_out), 0);
    exp_prod.delete();
    exp_ovf.delete();
    #1 rst_in = 1'b0;
    step(1'b1, 321, 21, 9, 1'b0);
    idle(6);
    check("post_rst_latency", 32'(data_valid_out), 1);
    idle(3);

    // Random traffic with random pauses
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 3) != 0), pick_operand(), pick_operand(), pick_operand(),
           ($urandom_range(0, 7) == 0));
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
